alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequential initiator that drives the team's combinational 16-bit ALU block through its A/B/alu_code/C/overflow interface. Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8x16 register file. Presents operands and opcode to the ALU, captures C/overflow and writes the result back. Sits between the instruction source (test sequencer or future fetch unit) and the ALU.

Parameters:
NREGS, 8, register-file depth (power of 2; address width = log2(NREGS), 3 at default)
DW, 16, datapath width (must match ALU)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word valid
instr_ready  out  1  block can accept instruction
instr  in  16  [15:11] alu_code, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] reserved (ignored)
ld_en  in  1  register-file preload strobe
ld_addr  in  3  preload address
ld_data  in  DW  preload data
rb_addr  in  3  readback address
rb_data  out  DW  combinational readback of reg[rb_addr]
alu_a  out  DW  to ALU A
alu_b  out  DW  to ALU B
alu_code  out  5  to ALU alu_code
alu_c  in  DW  from ALU C
alu_ovf  in  1  from ALU overflow
done  out  1  one-cycle pulse: instruction retired
result  out  DW  result of last retired instruction
ovf  out  1  overflow of last retired instruction
illegal  out  1  one-cycle pulse: illegal opcode rejected

Behaviour:
- Reset (async, rst_n low): state IDLE, all regs 0, alu_a/alu_b/alu_code/result = 0, ovf/done/illegal = 0, instr_ready = 0 while rst_n low.
- FSM states: IDLE, EXEC, WB.
- IDLE: instr_ready = 1. On instr_valid && instr_ready: latch fields. Legal opcode -> EXEC; illegal -> pulse illegal next cycle, remain IDLE, no writeback.
- Legal alu_code: 00xxx (all 8); 01 with 000/001/010/100; 10 with 000..011; 11 with 000..101. Everything else is illegal.
- EXEC (1 cycle): alu_a = reg[rs1], alu_b = reg[rs2], alu_code registered from instruction; instr_ready = 0. Always -> WB.
- WB: reg[rd] <= alu_c; result <= alu_c; ovf <= alu_ovf (0 for non-arith codes per ALU); done pulses high the cycle after WB with result/ovf valid. -> IDLE.
- Throughput: one instruction per 3 cycles; accept-to-done latency 3 cycles.
- alu_a/alu_b/alu_code hold last values outside EXEC (no toggling).
- Preload: ld_en writes reg[ld_addr] only in IDLE; ignored elsewhere. ld_en in the same IDLE cycle as an accepted instruction: preload write is performed first. Operands read in EXEC see the new value.
- WB with rd == rs1/rs2: write occurs after operand use; no hazard (serialized).
- Reset mid-EXEC/WB: instruction dropped, no done, no writeback.
- result/ovf hold until next retirement.

Optional Feature:
STICKY_OVF_EN: adds input ovf_clr (1 bit) and output ovf_sticky (1 bit). ovf_sticky sets on any retirement with alu_ovf = 1 and clears on ovf_clr. Set wins on the same cycle. Reset value 0. Without the macro, neither port exists.

Decomposition:
- Shared package alu_pkg holds:
  - state enum {IDLE, EXEC, WB}
  - alu_code group constants (GRP_ARITH = 2'b00, GRP_LOGIC = 2'b01, GRP_SHIFT = 2'b10, GRP_CMP = 2'b11)
  - instruction field bit positions
  - the opcode-legal function
- One sub-module is natural: alu_regfile (8x16, one write port, three async read ports for rs1, rs2 and readback).

Test Plan:
1. Preload r1 = 0x0005, r2 = 0x0003; issue code 00000 (add) rd = 3 -> done after 3 cycles, result = 0x0008, ovf = 0, rb r3 = 0x0008.
2. r1 = 0x7FFF, r2 = 0x0001, add -> result = 0x8000, ovf = 1. With STICKY_OVF_EN: ovf_sticky = 1 until ovf_clr.
3. Issue code 01011 -> illegal pulse next cycle, no done, rd unchanged, instr_ready stays 1.
4. r1 = 0xFFFE (−2), r2 = 0x0001, code 11001 (A<B) rd = 4 -> result = 0x0001.
5. Hold instr_valid for two back-to-back words -> second accepted only when the FSM returns to IDLE (3-cycle spacing), both retire in order.
6. Assert rst_n low during EXEC -> no done, target register stays 0, all outputs 0, instr_ready = 1 one cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types, field positions and opcode legality for the ALU issue controller.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_t;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHIFT = 2'b10;
    localparam logic [1:0] GRP_CMP   = 2'b11;

    localparam int INSTR_W = 16;
    localparam int CODE_W  = 5;
    localparam int CODE_LO = 11;
    localparam int RD_LO   = 8;
    localparam int RS1_LO  = 5;
    localparam int RS2_LO  = 2;

    // Logic group only implements and/or/xor/not; shift and compare groups are dense from zero.
    function automatic logic op_legal(input logic [4:0] code);
        logic legal;
        legal = 1'b0;
        case (code[4:3])
            GRP_ARITH: legal = 1'b1;
            GRP_LOGIC: legal = (code[2:0] == 3'b000) || (code[2:0] == 3'b001) ||
                               (code[2:0] == 3'b010) || (code[2:0] == 3'b100);
            GRP_SHIFT: legal = (code[2:0] <= 3'b011);
            GRP_CMP:   legal = (code[2:0] <= 3'b101);
            default:   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction valid/ready handshake between the instruction source and the issue controller.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/alu_regfile.sv
// Register file: one synchronous write port, three asynchronous read ports.
module alu_regfile #(
    parameter int NREGS = 8,
    parameter int DW    = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    input  logic [AW-1:0] raddr3,
    output logic [DW-1:0] rdata3
);

    logic [DW-1:0] mem_r [NREGS];

    // Storage array, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata1 = mem_r[raddr1];
    assign rdata2 = mem_r[raddr2];
    assign rdata3 = mem_r[raddr3];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller driving a combinational ALU: accept, execute, write back.
// Optional STICKY_OVF_EN adds ovf_clr / ovf_sticky.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   instr_if,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DW-1:0]     ld_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DW-1:0]     rb_data,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [CODE_W-1:0] alu_code,
    input  logic [DW-1:0]     alu_c,
    input  logic              alu_ovf,
    output logic              done,
    output logic [DW-1:0]     result,
    output logic              ovf,
    output logic              illegal
`ifdef STICKY_OVF_EN
    ,
    input  logic              ovf_clr,
    output logic              ovf_sticky
`endif
);

    state_t              state_r;
    logic                ready_r;
    logic [CODE_W-1:0]   code_r;
    logic [AW-1:0]       rd_r;
    logic [AW-1:0]       rs1_r;
    logic [AW-1:0]       rs2_r;
    logic [DW-1:0]       alu_a_r;
    logic [DW-1:0]       alu_b_r;
    logic [CODE_W-1:0]   alu_code_r;
    logic [DW-1:0]       result_r;
    logic                ovf_r;
    logic                done_r;
    logic                illegal_r;

    logic                we_s;
    logic [AW-1:0]       waddr_s;
    logic [DW-1:0]       wdata_s;
    logic [DW-1:0]       rs1_data_s;
    logic [DW-1:0]       rs2_data_s;
    logic [CODE_W-1:0]   in_code_s;
    logic                unused_s;

    assign in_code_s = instr_if.instr[CODE_LO +: CODE_W];
    assign unused_s  = ^instr_if.instr[1:0];

    // Write port arbitration: writeback in WB, preload only while IDLE.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = ld_addr;
        wdata_s = ld_data;
        if (state_r == WB) begin
            we_s    = 1'b1;
            waddr_s = rd_r;
            wdata_s = alu_c;
        end else if ((state_r == IDLE) && ld_en) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    alu_regfile #(.NREGS(NREGS), .DW(DW), .AW(AW)) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we_s),
        .waddr  (waddr_s),
        .wdata  (wdata_s),
        .raddr1 (rs1_r),
        .rdata1 (rs1_data_s),
        .raddr2 (rs2_r),
        .rdata2 (rs2_data_s),
        .raddr3 (rb_addr),
        .rdata3 (rb_data)
    );

    // Issue FSM; operands are sampled at the end of EXEC so a same-cycle preload is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ready_r    <= 1'b0;
            code_r     <= '0;
            rd_r       <= '0;
            rs1_r      <= '0;
            rs2_r      <= '0;
            alu_a_r    <= '0;
            alu_b_r    <= '0;
            alu_code_r <= '0;
            result_r   <= '0;
            ovf_r      <= 1'b0;
            done_r     <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b1;
                    if (instr_if.instr_valid && ready_r) begin
                        code_r <= in_code_s;
                        rd_r   <= instr_if.instr[RD_LO +: AW];
                        rs1_r  <= instr_if.instr[RS1_LO +: AW];
                        rs2_r  <= instr_if.instr[RS2_LO +: AW];
                        if (op_legal(in_code_s)) begin
                            state_r <= EXEC;
                            ready_r <= 1'b0;
                        end else begin
                            illegal_r <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    alu_a_r    <= rs1_data_s;
                    alu_b_r    <= rs2_data_s;
                    alu_code_r <= code_r;
                    ready_r    <= 1'b0;
                    state_r    <= WB;
                end
                WB: begin
                    result_r <= alu_c;
                    ovf_r    <= alu_ovf;
                    done_r   <= 1'b1;
                    ready_r  <= 1'b1;
                    state_r  <= IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign instr_if.instr_ready = ready_r;
    assign alu_a    = alu_a_r;
    assign alu_b    = alu_b_r;
    assign alu_code = alu_code_r;
    assign result   = result_r;
    assign ovf      = ovf_r;
    assign done     = done_r;
    assign illegal  = illegal_r;

`ifdef STICKY_OVF_EN
    logic ovf_sticky_r;

    // Sticky overflow: a retiring overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_r <= 1'b0;
        end else if ((state_r == WB) && alu_ovf) begin
            ovf_sticky_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_r <= 1'b0;
        end
    end

    assign ovf_sticky = ovf_sticky_r;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, corner sequences, random vs model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  rb_addr;
    logic [15:0] rb_data;
    logic [15:0] alu_a, alu_b, alu_c, result;
    logic [4:0]  alu_code;
    logic        alu_ovf, done, ovf, illegal;
`ifdef STICKY_OVF_EN
    logic        ovf_clr;
    logic        ovf_sticky;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if ifc ();

    alu_issue_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr_if (ifc),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rb_addr  (rb_addr),
        .rb_data  (rb_data),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_code (alu_code),
        .alu_c    (alu_c),
        .alu_ovf  (alu_ovf),
        .done     (done),
        .result   (result),
        .ovf      (ovf),
        .illegal  (illegal)
`ifdef STICKY_OVF_EN
        ,
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky)
`endif
    );

    // Behavioural ALU: returns {overflow, C}.
    function automatic logic [16:0] alu_fn(input logic [4:0] code, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] c;
        logic        v;
        logic [31:0] t;
        c = 16'h0000;
        v = 1'b0;
        t = {a, a} << b[3:0];
        case (code)
            5'b00000: begin c = a + b; v = (a[15] == b[15]) && (c[15] != a[15]); end
            5'b00001: begin c = a - b; v = (a[15] != b[15]) && (c[15] != a[15]); end
            5'b00010: begin c = a + 16'd1; v = (a == 16'h7FFF); end
            5'b00011: begin c = a - 16'd1; v = (a == 16'h8000); end
            5'b01000: c = a & b;
            5'b01001: c = a | b;
            5'b01010: c = a ^ b;
            5'b01100: c = ~a;
            5'b10000: c = a << b[3:0];
            5'b10001: c = a >> b[3:0];
            5'b10010: c = $signed(a) >>> b[3:0];
            5'b10011: c = t[31:16];
            5'b11000: c = {15'd0, a == b};
            5'b11001: c = {15'd0, $signed(a) < $signed(b)};
            5'b11010: c = {15'd0, $signed(a) > $signed(b)};
            5'b11011: c = {15'd0, a < b};
            5'b11100: c = {15'd0, a > b};
            5'b11101: c = {15'd0, a != b};
            default:  c = a;
        endcase
        return {v, c};
    endfunction

    always_comb begin
        {alu_ovf, alu_c} = alu_fn(alu_code, alu_a, alu_b);
    end

    logic [7:0] legal_mask [4];
    logic [15:0] mdl [8];
    logic        mdl_sticky;

    function automatic bit is_legal(input logic [4:0] code);
        logic [7:0] m;
        m = legal_mask[code[4:3]];
        return m[code[2:0]];
    endfunction

    function automatic logic [15:0] enc(input logic [4:0] code, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {code, rd, rs1, rs2, 2'b00};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ifc.instr_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ready_timeout", {31'd0, ifc.instr_ready}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] r1;
        logic [15:0] r2;
        logic [4:0]  code;
        logic [2:0]  rd;
        logic [15:0] exp_res;
        logic        exp_ovf;
        logic        exp_ill;
        logic [15:0] exp_rb;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [15:0] last_res;
        logic        last_ovf;
        logic [16:0] ref_v;
        logic [4:0]  rc;
        logic [2:0]  rrd, rs1, rs2;

        legal_mask[0] = 8'hFF;
        legal_mask[1] = 8'h17;
        legal_mask[2] = 8'h0F;
        legal_mask[3] = 8'h3F;

        vecs[0] = '{16'h0005, 16'h0003, 5'b00000, 3'd3, 16'h0008, 1'b0, 1'b0, 16'h0008};
        vecs[1] = '{16'h7FFF, 16'h0001, 5'b00000, 3'd3, 16'h8000, 1'b1, 1'b0, 16'h8000};
        vecs[2] = '{16'h1234, 16'h5678, 5'b01011, 3'd5, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vecs[3] = '{16'hFFFE, 16'h0001, 5'b11001, 3'd4, 16'h0001, 1'b0, 1'b0, 16'h0001};
        vecs[4] = '{16'h00F0, 16'h0FF0, 5'b01000, 3'd6, 16'h00F0, 1'b0, 1'b0, 16'h00F0};
        vecs[5] = '{16'h0001, 16'h0004, 5'b10000, 3'd7, 16'h0010, 1'b0, 1'b0, 16'h0010};
        vecs[6] = '{16'h8000, 16'h0001, 5'b00001, 3'd3, 16'h7FFF, 1'b1, 1'b0, 16'h7FFF};
        vecs[7] = '{16'h1111, 16'h2222, 5'b11110, 3'd6, 16'h0000, 1'b0, 1'b1, 16'h00F0};
        vecs[8] = '{16'h0100, 16'h0001, 5'b00000, 3'd1, 16'h0101, 1'b0, 1'b0, 16'h0101};

        rst_n = 1'b0;
        ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0000; rb_addr = 3'd0;
        ifc.instr_valid = 1'b0; ifc.instr = 16'h0000;
`ifdef STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        mdl_sticky = 1'b0;
        last_res = 16'h0000;
        last_ovf = 1'b0;

        // Reset state
        step(); step();
        chk("rst_ready", {31'd0, ifc.instr_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_alu_code", {27'd0, alu_code}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_ready", {31'd0, ifc.instr_ready}, 32'd1);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            wait_ready();
            ld_en = 1'b1; ld_addr = 3'd1; ld_data = vecs[i].r1;
            step();
            ld_addr = 3'd2; ld_data = vecs[i].r2;
            ifc.instr_valid = 1'b1;
            ifc.instr = enc(vecs[i].code, vecs[i].rd, 3'd1, 3'd2);
            step();
            ld_en = 1'b0; ifc.instr_valid = 1'b0;
            if (vecs[i].exp_ill) begin
                chk("ill_pulse", {31'd0, illegal}, 32'd1);
                chk("ill_no_done", {31'd0, done}, 32'd0);
                chk("ill_ready", {31'd0, ifc.instr_ready}, 32'd1);
                chk("ill_result_hold", {16'd0, result}, {16'd0, last_res});
                chk("ill_ovf_hold", {31'd0, ovf}, {31'd0, last_ovf});
                step();
                chk("ill_pulse_end", {31'd0, illegal}, 32'd0);
            end else begin
                chk("exec_done", {31'd0, done}, 32'd0);
                chk("exec_ready", {31'd0, ifc.instr_ready}, 32'd0);
                step();
                chk("wb_done", {31'd0, done}, 32'd0);
`ifdef STICKY_OVF_EN
                ovf_clr = 1'b1;
`endif
                step();
`ifdef STICKY_OVF_EN
                ovf_clr = 1'b0;
`endif
                chk("done", {31'd0, done}, 32'd1);
                chk("result", {16'd0, result}, {16'd0, vecs[i].exp_res});
                chk("ovf", {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
                mdl_sticky = vecs[i].exp_ovf;
                last_res = vecs[i].exp_res;
                last_ovf = vecs[i].exp_ovf;
                step();
                chk("done_one_cycle", {31'd0, done}, 32'd0);
            end
`ifdef STICKY_OVF_EN
            chk("sticky", {31'd0, ovf_sticky}, {31'd0, mdl_sticky});
`endif
            rb_addr = vecs[i].rd;
            #1;
            chk("rb_rd", {16'd0, rb_data}, {16'd0, vecs[i].exp_rb});
        end

        // Held valid: second word accepted three cycles later, retires in order
        wait_ready();
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'h0010;
        step();
        ld_addr = 3'd2; ld_data = 16'h0020;
        step();
        ld_en = 1'b0;
        ifc.instr_valid = 1'b1;
        ifc.instr = enc(5'b00000, 3'd3, 3'd1, 3'd2);
        step();
        chk("b2b_ready_exec", {31'd0, ifc.instr_ready}, 32'd0);
        ifc.instr = enc(5'b00001, 3'd4, 3'd3, 3'd1);
        step();
        chk("b2b_ready_wb", {31'd0, ifc.instr_ready}, 32'd0);
        chk("b2b_done_early", {31'd0, done}, 32'd0);
        step();
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_result1", {16'd0, result}, 32'h0030);
        chk("b2b_ready_idle", {31'd0, ifc.instr_ready}, 32'd1);
        step();
        ifc.instr_valid = 1'b0;
        chk("b2b_second_accepted", {31'd0, ifc.instr_ready}, 32'd0);
        step();
        chk("b2b_done2_early", {31'd0, done}, 32'd0);
        step();
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_result2", {16'd0, result}, 32'h0020);
        step();
        chk("alu_code_hold", {27'd0, alu_code}, 32'h01);
        chk("alu_a_hold", {16'd0, alu_a}, 32'h0030);

        // Reset asserted during EXEC
        wait_ready();
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'h0005;
        step();
        ld_addr = 3'd2; ld_data = 16'h0003;
        ifc.instr_valid = 1'b1;
        ifc.instr = enc(5'b00000, 3'd5, 3'd1, 3'd2);
        step();
        ld_en = 1'b0; ifc.instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, ifc.instr_ready}, 32'd0);
        chk("mid_rst_result", {16'd0, result}, 32'd0);
        chk("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("mid_rst_alu_b", {16'd0, alu_b}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_low", {31'd0, ifc.instr_ready}, 32'd0);
        step();
        chk("rel_ready_high", {31'd0, ifc.instr_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_no_done", {31'd0, done}, 32'd0);
            step();
        end
        rb_addr = 3'd5;
        #1;
        chk("mid_rst_rd_zero", {16'd0, rb_data}, 32'd0);
        mdl_sticky = 1'b0;
`ifdef STICKY_OVF_EN
        chk("mid_rst_sticky", {31'd0, ovf_sticky}, 32'd0);
`endif

        // Randomized instructions against the model
        wait_ready();
        for (int r = 0; r < 8; r++) begin
            ld_en = 1'b1;
            ld_addr = 3'(r);
            ld_data = 16'($urandom);
            mdl[r] = ld_data;
            step();
        end
        ld_en = 1'b0;
        for (int n = 0; n < 40; n++) begin
            wait_ready();
            rc  = 5'($urandom_range(0, 31));
            rrd = 3'($urandom_range(0, 7));
            rs1 = 3'($urandom_range(0, 7));
            rs2 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                ld_en = 1'b1;
                ld_addr = 3'($urandom_range(0, 7));
                ld_data = 16'($urandom);
                mdl[ld_addr] = ld_data;
            end
            ref_v = alu_fn(rc, mdl[rs1], mdl[rs2]);
            ifc.instr_valid = 1'b1;
            ifc.instr = enc(rc, rrd, rs1, rs2);
            step();
            ld_en = 1'b0; ifc.instr_valid = 1'b0;
            if (!is_legal(rc)) begin
                chk("rnd_illegal", {31'd0, illegal}, 32'd1);
                chk("rnd_ill_ready", {31'd0, ifc.instr_ready}, 32'd1);
                step();
            end else begin
                chk("rnd_legal", {31'd0, illegal}, 32'd0);
                step(); step();
                chk("rnd_done", {31'd0, done}, 32'd1);
                chk("rnd_result", {16'd0, result}, {16'd0, ref_v[15:0]});
                chk("rnd_ovf", {31'd0, ovf}, {31'd0, ref_v[16]});
                mdl[rrd] = ref_v[15:0];
                mdl_sticky = mdl_sticky | ref_v[16];
            end
            if (n % 5 == 4) begin
                rb_addr = 3'($urandom_range(0, 7));
                #1;
                chk("rnd_rb", {16'd0, rb_data}, {16'd0, mdl[rb_addr]});
            end
        end
        step();
        for (int r = 0; r < 8; r++) begin
            rb_addr = 3'(r);
            #1;
            chk("final_rb", {16'd0, rb_data}, {16'd0, mdl[r]});
        end
`ifdef STICKY_OVF_EN
        chk("final_sticky", {31'd0, ovf_sticky}, {31'd0, mdl_sticky});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
